program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Write-side counterpart of the program memory: turns a framed byte stream into sequential byte writes into the program memory array.
- The stream comes from a host link (UART RX or testbench driver).
- Holds the CPU in reset while loading and reports completion or error.
- Frame format: length (2 bytes, little-endian), then payload bytes, then a 1-byte checksum.

Parameters:
- ADDR_WIDTH, 10, program memory byte-address width (1 KB).
- MAX_LEN, 1024, maximum accepted payload length in bytes.
- BASE_ADDR, 0, byte address that receives the first payload byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a load when idle.
- s_valid  input  1  stream byte valid.
- s_data  input  8  stream byte.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  program memory byte write enable.
- mem_addr  output  32  write byte address; zero-extended above ADDR_WIDTH.
- mem_wdata  output  8  write byte.
- busy  output  1  load in progress.
- cpu_hold  output  1  holds the CPU in reset; equals busy.
- done  output  1  last load completed with good checksum.
- err  output  1  last load failed (length or checksum).

Behaviour:
- Reset: state IDLE. The following outputs and registers reset to 0: s_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err, length, index and checksum accumulator. Reset asserted mid-load aborts immediately; partially written bytes stay in memory.
- Handshake: a byte transfers on a rising edge with s_valid && s_ready. s_ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 otherwise. s_valid low stalls without side effects.
- FSM:
  - IDLE: start=1 clears done, err, index and sum, sets busy, and moves to LEN_LO.
  - LEN_LO: accept byte into len[7:0], then go to LEN_HI.
  - LEN_HI: accept byte into len[15:8].
    - If len > MAX_LEN, go to ERR; no memory writes occur.
    - If len = 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA: each accepted byte b does the following:
    - next cycle mem_we=1 for exactly one cycle;
    - mem_addr = (BASE_ADDR + index) mod 2^ADDR_WIDTH;
    - mem_wdata = b;
    - sum += b (mod 256);
    - index increments.
    - After byte index len-1 is accepted, go to CSUM.
  - CSUM: accept byte c.
    - If c == sum, go to DONE.
    - Otherwise go to ERR.
  - DONE: busy=0 and done=1, then go to IDLE. done is a level held until the next start or rst.
  - ERR: busy=0 and err=1, then go to IDLE. err is a level held until the next start or rst.
- Write latency: mem_we/addr/wdata are registered and appear 1 cycle after the accepting edge. Back-to-back accepted bytes give back-to-back write cycles. When mem_we=0, mem_addr and mem_wdata hold their last values.
- busy rises the cycle after start and falls the cycle after the checksum byte or after an oversized LEN_HI.
- The last data write (mem_we) completes before or on the cycle busy falls.
- start while busy is ignored. Bytes presented in IDLE/DONE/ERR are not accepted (s_ready=0).
- Address wrap: when BASE_ADDR + len exceeds 2^ADDR_WIDTH, the address wraps to 0; this is not an error.
- len == MAX_LEN exactly is legal.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse; s_valid=1 held for 10 cycles.
  - Response: s_ready=0; no mem_we; busy=cpu_hold=done=err=0.
- Good load:
  - Stimulus: start; stream 04 00 13 05 A0 00 B8.
  - Response: writes addr0=13, 1=05, 2=A0, 3=00 on consecutive cycles; done=1; err=0; busy low afterwards.
- Stalls:
  - Stimulus: the same frame with s_valid deasserted 3 cycles between each byte.
  - Response: identical write contents; mem_we pulses are each exactly 1 cycle; done=1.
- Bad checksum:
  - Stimulus: frame 02 00 11 22 00.
  - Response: writes 11 and 22 occur at addr 0 and 1; err=1; done=0.
- Oversize and zero length:
  - Stimulus: frame 01 04 (len = 1025 > MAX_LEN).
  - Response: err=1 with no mem_we.
  - Stimulus: frame 00 00 00.
  - Response: done=1 with no mem_we.
- Wrap and abort:
  - Stimulus: BASE_ADDR=1022, frame 03 00 AA BB CC 31.
  - Response: writes to addr 1022, 1023, 0.
  - Stimulus: a second load with rst asserted mid-DATA.
  - Response: all outputs return to 0 immediately; a later start loads normally.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: turns a framed byte stream (len16 LE, payload, checksum) into
// sequential program-memory byte writes, holding the CPU in reset while busy.
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_LEN    = 1024,
    parameter int BASE_ADDR  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE_S,
        ERR_S
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [15:0]           MAX_LEN_W = 16'(MAX_LEN);

    state_t                  state;
    logic [15:0]             len;
    logic [15:0]             index;
    logic [7:0]              sum;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    xfer;
    logic [15:0]             len_full;

    assign s_ready  = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CSUM);
    assign xfer     = s_valid && s_ready;
    assign len_full = {s_data, len[7:0]};
    assign mem_addr = 32'(addr_q);
    assign cpu_hold = busy;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            index     <= '0;
            sum       <= '0;
            addr_q    <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        index <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= s_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len <= len_full;
                        if (len_full > MAX_LEN_W) begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= ERR_S;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // Address arithmetic is modulo the memory size, so loads wrap to 0.
                        mem_we    <= 1'b1;
                        addr_q    <= BASE + ADDR_WIDTH'(index);
                        mem_wdata <= s_data;
                        sum       <= sum + s_data;
                        index     <= index + 16'd1;
                        if (index == len - 16'd1) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (s_data == sum) begin
                            done  <= 1'b1;
                            state <= DONE_S;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR_S;
                        end
                    end
                end
                DONE_S:  state <= IDLE;
                ERR_S:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader; two instances (base 0 and
// base 1022) share stimulus and are checked against a frame-level model.
module tb_program_loader;

    localparam int AW      = 10;
    localparam int MAX_LEN = 1024;
    localparam int BASE_A  = 0;
    localparam int BASE_B  = 1022;
    localparam int TMO     = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;

    logic        s_ready_a, mem_we_a, busy_a, cpu_hold_a, done_a, err_a;
    logic [31:0] mem_addr_a;
    logic [7:0]  mem_wdata_a;
    logic        s_ready_b, mem_we_b, busy_b, cpu_hold_b, done_b, err_b;
    logic [31:0] mem_addr_b;
    logic [7:0]  mem_wdata_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    wr_t qa[$];
    wr_t qb[$];

    program_loader #(.ADDR_WIDTH(AW), .MAX_LEN(MAX_LEN), .BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .busy(busy_a), .cpu_hold(cpu_hold_a),
        .done(done_a), .err(err_a)
    );

    program_loader #(.ADDR_WIDTH(AW), .MAX_LEN(MAX_LEN), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .busy(busy_b), .cpu_hold(cpu_hold_b),
        .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Write monitor: one entry per cycle that mem_we is high.
    always @(negedge clk) begin
        if (mem_we_a) qa.push_back('{mem_addr_a, mem_wdata_a, cyc});
        if (mem_we_b) qb.push_back('{mem_addr_b, mem_wdata_b, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'({s_ready_a, s_ready_b}), 32'd0);
        check({tag, "_mem_we"}, 32'({mem_we_a, mem_we_b}), 32'd0);
        check({tag, "_busy_hold"}, 32'({busy_a, busy_b, cpu_hold_a, cpu_hold_b}), 32'd0);
        check({tag, "_done_err"}, 32'({done_a, done_b, err_a, err_b}), 32'd0);
        check({tag, "_addr"}, mem_addr_a | mem_addr_b, 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata_a | mem_wdata_b), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int n;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        start   = poke;
        n = 0;
        while (!s_ready_a && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("handshake_timeout", 32'(n < TMO), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Frame-level model: decode length, payload, checksum; derive expected writes and status.
    task automatic run_load(input string tag, input bq_t f, input int gap, input bit poke);
        int          len;
        bit          over;
        bit          ok;
        int          nsend;
        int          nwr;
        logic [7:0]  sum;
        len  = int'({f[1], f[0]});
        over = len > MAX_LEN;
        sum  = 8'h00;
        if (!over) for (int i = 0; i < len; i++) sum = sum + f[2 + i];
        ok    = !over && (f[2 + len] == sum);
        nsend = over ? 2 : len + 3;
        nwr   = over ? 0 : len;
        qa.delete();
        qb.delete();
        pulse_start();
        check({tag, "_busy_rise"}, 32'({busy_a, cpu_hold_a, busy_b, cpu_hold_b}), 32'hF);
        check({tag, "_status_clear"}, 32'({done_a, err_a, done_b, err_b}), 32'd0);
        for (int i = 0; i < nsend; i++) send_byte(f[i], gap, poke && i == 3 && nsend > 5);
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, "_busy_fall"}, 32'({busy_a, cpu_hold_a, busy_b, cpu_hold_b}), 32'd0);
        check({tag, "_done_err"}, 32'({done_a, err_a, done_b, err_b}),
              32'({ok, !ok, ok, !ok}));
        repeat (3) @(negedge clk);
        check({tag, "_status_held"}, 32'({done_a, err_a, s_ready_a}), 32'({ok, !ok, 1'b0}));
        check({tag, "_nwrites_a"}, 32'(qa.size()), 32'(nwr));
        check({tag, "_nwrites_b"}, 32'(qb.size()), 32'(nwr));
        if (qa.size() == nwr && qb.size() == nwr) begin
            for (int i = 0; i < nwr; i++) begin
                check({tag, "_addr_a"}, qa[i].addr, 32'((BASE_A + i) % (1 << AW)));
                check({tag, "_addr_b"}, qb[i].addr, 32'((BASE_B + i) % (1 << AW)));
                check({tag, "_data_a"}, 32'(qa[i].data), 32'(f[2 + i]));
                check({tag, "_data_b"}, 32'(qb[i].data), 32'(f[2 + i]));
                if (gap == 0 && !poke && i > 0)
                    check({tag, "_back_to_back"}, 32'(qa[i].cyc - qa[i - 1].cyc), 32'd1);
            end
        end
    endtask

    initial begin
        bq_t f;
        int  len;
        logic [7:0] sum;

        // Reset then idle with s_valid held high.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 32'({s_ready_a, s_ready_b, mem_we_a, mem_we_b}), 32'd0);
            check("idle_status", 32'({busy_a, cpu_hold_a, done_a, err_a}), 32'd0);
        end
        s_valid = 1'b0;

        f = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
        run_load("good", f, 0, 1'b0);
        run_load("stall", f, 3, 1'b0);

        f = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h00};
        run_load("badsum", f, 0, 1'b0);

        f = '{8'h01, 8'h04};
        run_load("oversize", f, 0, 1'b0);

        f = '{8'h00, 8'h00, 8'h00};
        run_load("zero", f, 0, 1'b0);

        f = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        run_load("wrap", f, 0, 1'b0);

        // Exactly MAX_LEN bytes is legal.
        f = '{8'h00, 8'h04};
        sum = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            f.push_back(8'($urandom));
            sum = sum + f[f.size() - 1];
        end
        f.push_back(sum);
        run_load("maxlen", f, 0, 1'b0);

        // Abort mid-DATA with rst; outputs clear immediately.
        pulse_start();
        f = '{8'h08, 8'h00, 8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 5; i++) send_byte(f[i], 0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        f = '{8'h02, 8'h00, 8'h7F, 8'h01, 8'h80};
        run_load("after_abort", f, 0, 1'b0);

        // Random frames: mixed lengths, corrupted checksums, stalls, start while busy.
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                len = MAX_LEN + 1 + int'($urandom_range(0, 5000));
                f = '{8'(len), 8'(len >> 8)};
            end else begin
                len = int'($urandom_range(0, 24));
                f = '{8'(len), 8'(len >> 8)};
                sum = 8'h00;
                for (int i = 0; i < len; i++) begin
                    f.push_back(8'($urandom));
                    sum = sum + f[f.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) sum = sum ^ 8'(1 + $urandom_range(0, 254));
                f.push_back(sum);
            end
            run_load("random", f, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
